// File: rtl/sccb_pkg.sv
// Shared SCCB definitions: FSM state encoding, quarter/phase constants and the
// quarter-period helper used by the write master and by configuration logic.
package sccb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_BIT,
        ST_STOP,
        ST_BUF
    } sccb_state_e;

    localparam logic [1:0] Q0 = 2'd0;
    localparam logic [1:0] Q1 = 2'd1;
    localparam logic [1:0] Q2 = 2'd2;
    localparam logic [1:0] Q3 = 2'd3;

    localparam int QTRS_PER_STATE   = 4;
    localparam int STATES_PER_FRAME = 30;

    // Bit index 8..1 carries data bits 7..0; index 0 is the don't-care ninth bit.
    localparam logic [3:0] BIT_FIRST = 4'd8;
    localparam logic [3:0] BIT_ACK   = 4'd0;
    localparam logic [1:0] BYTE_LAST = 2'd2;

    function automatic int qtr_clocks(input int clk_f, input int sccb_f);
        return clk_f / (4 * sccb_f);
    endfunction

endpackage

// File: rtl/sccb_qtr_tick.sv
// Quarter-bit timebase: one-cycle tick every QTR clocks, realigned whenever a
// new transaction is accepted so the first quarter is always full length.
module sccb_qtr_tick #(
    parameter int QTR = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_restart,
    output logic o_tick
);

    localparam int              CW      = (QTR > 1) ? $clog2(QTR) : 1;
    localparam logic [CW-1:0]   CNT_TOP = CW'(QTR - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q - CW'(1);
        if (i_restart || (cnt_q == '0)) begin
            cnt_d = CNT_TOP;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_tick = (cnt_q == '0);

endmodule

// File: rtl/sccb_write_master.sv
// SCCB 3-phase write master: sends CAM_ID, register address and data framed by
// START/STOP, followed by a bus-free interval, on an open-drain style SIOD.
module sccb_write_master
    import sccb_pkg::*;
#(
    parameter int          CLK_F  = 100_000_000,
    parameter int          SCCB_F = 100_000,
    parameter logic [7:0]  CAM_ID = 8'h42
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_start,
    input  logic [7:0] i_addr,
    input  logic [7:0] i_data,
    output logic       o_ready,
    output logic       o_sioc,
    output logic       o_siod,
    output logic       o_siod_en
);

    localparam int QTR = qtr_clocks(CLK_F, SCCB_F);

    generate
        if (QTR < 2) begin : g_bad_qtr
            $error("sccb_write_master: CLK_F/(4*SCCB_F) must be at least 2");
        end
    endgenerate

    sccb_state_e state_q, state_d;
    logic [1:0]  qtr_q, qtr_d;
    logic [3:0]  bit_q, bit_d;
    logic [1:0]  byte_q, byte_d;
    logic [7:0]  addr_q, addr_d;
    logic [7:0]  data_q, data_d;
    logic        sioc_q, sioc_d;
    logic        siod_q, siod_d;
    logic        siod_en_q, siod_en_d;

    logic        accept;
    logic        tick;
    logic [7:0]  cur_byte;
    logic        cur_bit;

    assign accept = (state_q == ST_IDLE) && i_start;

    sccb_qtr_tick #(
        .QTR (QTR)
    ) u_tick (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_restart (accept),
        .o_tick    (tick)
    );

    always_comb begin
        state_d = state_q;
        qtr_d   = qtr_q;
        bit_d   = bit_q;
        byte_d  = byte_q;
        addr_d  = addr_q;
        data_d  = data_q;

        if (state_q == ST_IDLE) begin
            if (i_start) begin
                state_d = ST_START;
                qtr_d   = Q0;
                bit_d   = BIT_FIRST;
                byte_d  = '0;
                addr_d  = i_addr;
                data_d  = i_data;
            end
        end else if (tick) begin
            qtr_d = qtr_q + 2'd1;
            if (qtr_q == Q3) begin
                unique case (state_q)
                    ST_START: begin
                        state_d = ST_BIT;
                        bit_d   = BIT_FIRST;
                        byte_d  = '0;
                    end
                    ST_BIT: begin
                        if (bit_q == BIT_ACK) begin
                            bit_d = BIT_FIRST;
                            if (byte_q == BYTE_LAST) begin
                                state_d = ST_STOP;
                            end else begin
                                byte_d = byte_q + 2'd1;
                            end
                        end else begin
                            bit_d = bit_q - 4'd1;
                        end
                    end
                    ST_STOP: state_d = ST_BUF;
                    ST_BUF:  state_d = ST_IDLE;
                    default: state_d = ST_IDLE;
                endcase
            end
        end
    end

    // Line levels are decoded from the next position so the registered outputs
    // line up with the state they belong to, including the first clock of q0.
    always_comb begin
        unique case (byte_d)
            2'd0:    cur_byte = CAM_ID;
            2'd1:    cur_byte = addr_d;
            2'd2:    cur_byte = data_d;
            default: cur_byte = 8'h00;
        endcase
        cur_bit = cur_byte[3'(bit_d - 4'd1)];

        sioc_d    = 1'b1;
        siod_d    = 1'b1;
        siod_en_d = 1'b0;

        unique case (state_d)
            ST_START: begin
                siod_en_d = 1'b1;
                sioc_d    = (qtr_d == Q0) || (qtr_d == Q1);
                siod_d    = (qtr_d == Q0);
            end
            ST_BIT: begin
                sioc_d    = (qtr_d == Q1) || (qtr_d == Q2);
                siod_en_d = (bit_d != BIT_ACK);
                siod_d    = siod_en_d ? cur_bit : 1'b1;
            end
            ST_STOP: begin
                siod_en_d = 1'b1;
                sioc_d    = (qtr_d != Q0);
                siod_d    = (qtr_d == Q2) || (qtr_d == Q3);
            end
            default: begin
                sioc_d    = 1'b1;
                siod_d    = 1'b1;
                siod_en_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q   <= ST_IDLE;
            qtr_q     <= '0;
            bit_q     <= '0;
            byte_q    <= '0;
            addr_q    <= '0;
            data_q    <= '0;
            sioc_q    <= 1'b1;
            siod_q    <= 1'b1;
            siod_en_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            qtr_q     <= qtr_d;
            bit_q     <= bit_d;
            byte_q    <= byte_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            sioc_q    <= sioc_d;
            siod_q    <= siod_d;
            siod_en_q <= siod_en_d;
        end
    end

    assign o_ready   = (state_q == ST_IDLE);
    assign o_sioc    = sioc_q;
    assign o_siod    = siod_q;
    assign o_siod_en = siod_en_q;

endmodule
